// File: rtl/step5_status_pipe.sv
// step5_status_pipe: elastic DEPTH-stage carrier for FP adder status
// (sign, five exception flags, user tag) with valid/ready handshake,
// sticky exception flags over accepted results, and registered occupancy.
// Optional: define FP_STATUS_ZERO_SIGN_EN to force exact-zero, non-NaN
// results to +0 at capture.
module step5_status_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int OCC_W = $clog2(DEPTH+1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [4:0]       in_flags,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [4:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  input  logic             sticky_clear,
  output logic [4:0]       sticky_flags,
  output logic [OCC_W-1:0] occupancy
);

  typedef struct packed {
    logic             sign;
    logic [4:0]       flags;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  stage_t           d [DEPTH];
  stage_t           cap;
  logic             accept;
  logic             beat;

  // Advance enables: a stage moves when any stage at or after it is empty,
  // or the consumer is taking the head. Accumulated without self-reference.
  always_comb begin
    logic acc;
    acc = out_ready | ~v[DEPTH-1];
    en  = '0;
    en[DEPTH-1] = acc;
    for (int i = DEPTH-2; i >= 0; i--) begin
      acc   = acc | ~v[i];
      en[i] = acc;
    end
  end

  // Stage-0 capture word, with optional +0 normalisation of exact zeros.
  always_comb begin
    cap.flags = in_flags;
    cap.tag   = in_tag;
`ifdef FP_STATUS_ZERO_SIGN_EN
    cap.sign  = in_sign & ~(in_flags[0] & ~in_flags[2]);
`else
    cap.sign  = in_sign;
`endif
  end

  assign in_ready = en[0];
  assign accept   = in_valid & in_ready;
  assign beat     = v[DEPTH-1] & out_ready;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      logic   vq;
      stage_t dq;
      logic   v_src;
      stage_t d_src;

      if (g == 0) begin : g_head
        assign v_src = in_valid;
        assign d_src = cap;
      end else begin : g_body
        assign v_src = v[g-1];
        assign d_src = d[g-1];
      end

      // Stage register: loads from upstream only when enabled; flush kills valid.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          vq <= 1'b0;
          dq <= '0;
        end else begin
          if (flush)      vq <= 1'b0;
          else if (en[g]) vq <= v_src;
          if (en[g])      dq <= d_src;
        end
      end

      assign v[g] = vq;
      assign d[g] = dq;
    end
  endgenerate

  // Output stage view, masked to zero while no result is held.
  always_comb begin
    out_valid = v[DEPTH-1];
    out_sign  = v[DEPTH-1] & d[DEPTH-1].sign;
    out_flags = v[DEPTH-1] ? d[DEPTH-1].flags : 5'b0;
    out_tag   = v[DEPTH-1] ? d[DEPTH-1].tag   : '0;
  end

  // Occupancy tracks accepts minus beats; flush empties the pipe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)               occupancy <= '0;
    else if (flush)            occupancy <= '0;
    else if (accept && !beat)  occupancy <= occupancy + OCC_W'(1);
    else if (beat && !accept)  occupancy <= occupancy - OCC_W'(1);
  end

  // Sticky flags: clear takes effect before a coincident beat is merged.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)           sticky_flags <= 5'b0;
    else if (sticky_clear) sticky_flags <= beat ? out_flags : 5'b0;
    else if (beat)         sticky_flags <= sticky_flags | out_flags;
  end

endmodule

// File: tb/tb_step5_status_pipe.sv
// Directed bench for step5_status_pipe: queue-based model of an elastic
// pipe checked every cycle, plus hand-computed literal expectations.
module tb_step5_status_pipe;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic             clock = 0;
  logic             resetn = 0;
  logic             flush = 0;
  logic             in_valid = 0;
  logic             in_ready;
  logic             in_sign = 0;
  logic [4:0]       in_flags = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 0;
  logic             out_sign;
  logic [4:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic             sticky_clear = 0;
  logic [4:0]       sticky_flags;
  logic [OCC_W-1:0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  step5_status_pipe #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_flags(in_flags), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_flags(out_flags), .out_tag(out_tag),
    .sticky_clear(sticky_clear), .sticky_flags(sticky_flags),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: ordered entries with a slot position ----------
  typedef struct {
    logic             s;
    logic [4:0]       f;
    logic [TAG_W-1:0] t;
    int               pos;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] m_sticky = '0;
  bit         m_beat, m_acc;
  logic [4:0] m_hf;
  ent_t       m_new;
  int         m_lim;

  function automatic logic stored_sign(input logic s, input logic [4:0] f);
`ifdef FP_STATUS_ZERO_SIGN_EN
    return (f[0] && !f[2]) ? 1'b0 : s;
`else
    return s;
`endif
  endfunction

  // Entries compress toward the output whenever a free slot lies ahead;
  // a new entry fits whenever the pipe is not full or the head is leaving.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_sticky = '0;
    end else begin
      m_beat = mq.size() > 0 && mq[0].pos == DEPTH-1 && out_ready;
      m_acc  = in_valid && (out_ready || mq.size() < DEPTH);
      m_hf   = m_beat ? mq[0].f : 5'b0;
      if (sticky_clear) m_sticky = m_hf;
      else              m_sticky = m_sticky | m_hf;
      if (flush) mq.delete();
      else begin
        if (m_beat) void'(mq.pop_front());
        for (int k = 0; k < mq.size(); k++) begin
          m_lim = (k == 0) ? DEPTH-1 : mq[k-1].pos - 1;
          if (mq[k].pos < m_lim) mq[k].pos = mq[k].pos + 1;
        end
        if (m_acc) begin
          m_new.s = stored_sign(in_sign, in_flags);
          m_new.f = in_flags;
          m_new.t = in_tag;
          m_new.pos = 0;
          mq.push_back(m_new);
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    logic ev;
    ev = mq.size() > 0 && mq[0].pos == DEPTH-1;
    chk("in_ready",  in_ready,  (out_ready || mq.size() < DEPTH));
    chk("out_valid", out_valid, ev);
    chk("out_sign",  out_sign,  ev ? mq[0].s : 1'b0);
    chk("out_flags", out_flags, ev ? mq[0].f : 5'b0);
    chk("out_tag",   out_tag,   ev ? mq[0].t : '0);
    chk("occupancy", occupancy, mq.size());
    chk("sticky",    sticky_flags, m_sticky);
  end

  // Record every output beat for ordering checks.
  logic [TAG_W-1:0] beats[$];
  always @(posedge clock) if (resetn && out_valid && out_ready) beats.push_back(out_tag);

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic send(input logic s, input logic [4:0] f, input logic [TAG_W-1:0] t);
    in_valid = 1; in_sign = s; in_flags = f; in_tag = t;
  endtask

  initial begin
    // reset
    repeat (2) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_sticky", sticky_flags, 0);
    resetn = 1;

    // latency: accept at edge 0, output after edge DEPTH
    out_ready = 1;
    send(1, 5'b00100, 3);
    step(); in_valid = 0;
    chk("lat_occ1", occupancy, 1);
    chk("lat_vld1", out_valid, 0);
    step();
    chk("lat_vld2", out_valid, 1);
    chk("lat_tag", out_tag, 3);
    chk("lat_sign", out_sign, 1);
    chk("lat_flags", out_flags, 5'b00100);
    step();
    chk("lat_occ_after", occupancy, 0);
    chk("lat_vld_after", out_valid, 0);
    chk("lat_sticky", sticky_flags, 5'b00100);

    // back-pressure
    beats.delete();
    out_ready = 0;
    send(0, 5'b0, 1); step();
    send(0, 5'b0, 2); step();
    send(0, 5'b0, 3); #1;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_occ", occupancy, 2);
    chk("bp_tag1", out_tag, 1);
    step();
    chk("bp_tag_stable", out_tag, 1);
    chk("bp_occ_stable", occupancy, 2);
    out_ready = 1;
    step(); in_valid = 0;
    repeat (3) step();
    chk("bp_count", beats.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("bp_order", (i < beats.size()) ? beats[i] : 4'hx, i + 1);

    // streaming
    beats.delete();
    for (int i = 0; i < 10; i++) begin
      send(i[0], 5'b0, i[TAG_W-1:0]); #1;
      chk("st_in_ready", in_ready, 1);
      if (i == 5) chk("st_occ", occupancy, DEPTH);
      step();
    end
    in_valid = 0;
    repeat (DEPTH + 1) step();
    chk("st_count", beats.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("st_order", (i < beats.size()) ? beats[i] : 4'hx, i);

    // flush with coincident input
    beats.delete();
    out_ready = 0;
    send(0, 5'b0, 7); step();
    send(0, 5'b0, 8); step();
    send(0, 5'b0, 9); flush = 1; step();
    flush = 0; in_valid = 0;
    chk("fl_vld", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    out_ready = 1;
    repeat (3) step();
    chk("fl_no_out", beats.size(), 0);

    // sticky
    sticky_clear = 1; step(); sticky_clear = 0;
    chk("sk_clear", sticky_flags, 0);
    out_ready = 0;
    send(0, 5'b01000, 1); step();
    send(0, 5'b00010, 2); step();
    send(0, 5'b00001, 3); out_ready = 1; step();
    in_valid = 0;
    chk("sk_1", sticky_flags, 5'b01000);
    step();
    chk("sk_2", sticky_flags, 5'b01010);
    sticky_clear = 1; step(); sticky_clear = 0;
    chk("sk_3", sticky_flags, 5'b00001);

    // zero sign
    send(1, 5'b00001, 5); step(); in_valid = 0; step();
`ifdef FP_STATUS_ZERO_SIGN_EN
    chk("zs_zero", out_sign, 0);
`else
    chk("zs_zero", out_sign, 1);
`endif
    send(1, 5'b00101, 6); step(); in_valid = 0; step();
    chk("zs_nan", out_sign, 1);
    step();

    // reset mid-stream
    beats.delete();
    out_ready = 0;
    send(1, 5'b10000, 4); step(); step(); in_valid = 0;
    resetn = 0; #1;
    chk("mr_vld", out_valid, 0);
    chk("mr_occ", occupancy, 0);
    chk("mr_sticky", sticky_flags, 0);
    step(); resetn = 1; out_ready = 1;
    repeat (3) step();
    chk("mr_no_out", beats.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/step5_status_pipe.md
Name: step5_status_pipe

Overview:
- Parametrised successor to the single-register adder-status stage of the FP MAC pipeline.
- Carries result sign, five exception flags and a user tag through DEPTH elastic register stages with valid/ready handshake.
- Keeps sticky exception flags for accepted results and reports how many entries are in flight.
- Sits between the adder/normaliser and the rounding/writeback stages.

Parameters:
- DEPTH, 2, number of register stages (>=1); latency in cycles with no stall.
- TAG_W, 4, width of the user tag carried alongside each result.
- OCC_W, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush: drops all in-flight entries.
- in_valid  in  1  producer has a result this cycle.
- in_ready  out  1  block accepts the input this cycle.
- in_sign  in  1  result sign.
- in_flags  in  5  {unf,ovf,nan,inf,zero}, bit0 = zero.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  last stage holds a result.
- out_ready  in  1  consumer accepts this cycle.
- out_sign  out  1  sign of the last stage.
- out_flags  out  5  flags of the last stage.
- out_tag  out  TAG_W  tag of the last stage.
- sticky_clear  in  1  synchronous clear of sticky_flags.
- sticky_flags  out  5  OR of out_flags over all accepted outputs since the last clear or reset.
- occupancy  out  OCC_W  number of valid stages.

Behaviour:
- Reset (resetn low, async): all stage valid bits = 0, stage data = 0, sticky_flags = 0. Outputs read 0: out_valid, out_sign, out_flags, out_tag, occupancy. Reset mid-stream discards all entries with no output beat.
- Stage i holds v[i] and d[i] = {sign, flags, tag}. Stage DEPTH-1 drives out_*.
- Advance enable is combinational:
  - en[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - en[i] = ~v[i] | en[i+1].
  - in_ready = en[0].
- On a clock edge where en[i] = 1:
  - v[i] <= v[i-1] and d[i] <= d[i-1].
  - Stage 0 loads in_valid and in_* instead.
- Data of stage i changes only when en[i] = 1. Data is never overwritten while v[i] = 1 and en[i] = 0.
- out_* stays stable while out_valid = 1 and out_ready = 0.
- Accept = in_valid & in_ready. Output beat = out_valid & out_ready.
- Latency is exactly DEPTH cycles from accept to out_valid with out_ready held high. Throughput is 1 per cycle.
- Full: all v = 1 and out_ready = 0 gives in_ready = 0. Empty: occupancy = 0 and out_valid = 0.
- With out_ready = 1, in_ready = 1 even when full (pass-through, no bubble).
- occupancy is registered and equals the popcount of v. It updates as +1 on accept without a beat, -1 on a beat without accept, and is unchanged when both or neither occur.
- flush = 1 at an edge:
  - All v <= 0 and occupancy <= 0. The input is dropped even if accepted that cycle. Flush has priority over in_valid.
  - An output beat in the same cycle still counts toward sticky_flags.
- sticky_flags at each edge:
  - sticky_clear = 1 and beat: loads out_flags (the clear applies first, the new beat survives).
  - sticky_clear = 1, no beat: loads 0.
  - Otherwise on a beat: sticky_flags | out_flags.
  - Otherwise: holds.
- in_* is ignored when in_valid = 0. The stored data for a bubble is don't-care, but out_* must read 0 while out_valid = 0 (mask at output).

Optional Feature:
- Macro: FP_STATUS_ZERO_SIGN_EN.
- Defined: at stage-0 capture, if in_flags[0] (zero) = 1 and in_flags[2] (nan) = 0, the stored sign is forced to 0 (exact-zero results are +0). Flags and tag are unaffected.
- Not defined: in_sign is stored unchanged.

Test Plan:
- Reset/latency: DEPTH=2. Release reset, hold out_ready=1. Accept sign=1, flags=5'b00100, tag=3 at cycle 0. Required: out_valid=1 with the same values at cycle 2; occupancy 1 at cycle 1, 0 after the beat.
- Back-pressure: DEPTH=2, out_ready=0. Send tags 1, 2, 3. Required: in_ready=0 after 2 accepts, occupancy=2, out_tag=1 stable. Raise out_ready. Required: tags 1, 2, 3 emerge in order with no loss or duplication.
- Streaming: out_ready=1 and in_valid=1 for 10 cycles with tags 0..9. Required: in_ready=1 throughout, ten consecutive beats starting at cycle DEPTH, occupancy constant at DEPTH in steady state.
- Flush: two entries in flight, pulse flush with in_valid=1. Required: next cycle out_valid=0, occupancy=0, the flushed-cycle input never appears at the output.
- Sticky: beats with flags 5'b01000 then 5'b00010, then sticky_clear coincident with a beat of 5'b00001. Required: sticky_flags = 5'b01000, then 5'b01010, then 5'b00001.
- Zero sign (macro defined): input sign=1, flags=5'b00001. Required: out_sign=0. With flags=5'b00101 (zero+nan): out_sign=1. Macro undefined: out_sign=1 in both cases.
